// File: rtl/iir_pole_mac.sv
// Time-multiplexed IIR pole section: one shared saturating multiply-accumulate
// evaluates sum c[k]*d[k-1] over ORDER taps, one tap per clock, with run-time coefficients.
module iir_pole_mac #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int ORDER = 7,
    parameter int ADRW  = 4,
    parameter int AW    = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din,
    output logic                 din_ready,
    input  logic                 coe_we,
    input  logic [ADRW-1:0]      coe_addr,
    input  logic signed [CW-1:0] coe_data,
    output logic                 coe_err,
    output logic                 dout_valid,
    output logic signed [AW-1:0] dout,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [ADRW-1:0]       idx_r;
    logic signed [DW-1:0]  dly_r  [ORDER];
    logic signed [CW-1:0]  coef_r [ORDER];   // coef_r[k-1] holds c[k]
    logic signed [AW-1:0]  acc_r;
    logic signed [AW-1:0]  dout_r;
    logic                  din_ready_r;
    logic                  dout_valid_r;
    logic                  coe_err_r;
    logic                  ovf_r;

    logic signed [DW-1:0]     tap_d_s;
    logic signed [CW-1:0]     tap_c_s;
    logic signed [DW+CW-1:0]  prod_s;
    logic signed [AW-1:0]     prod_ext_s;
    logic signed [AW-1:0]     acc_nxt_s;
    logic                     acc_hit_s;
    logic                     addr_ok_s;

    // Saturating signed add: clamp to the AW-bit two's complement range.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
        logic [AW:0] sum;
        sum = {a[AW-1], a} + {b[AW-1], b};
        if (sum[AW] != sum[AW-1]) begin
            sat_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            sat_add = sum[AW-1:0];
        end
    endfunction

    // Flags that the same addition left the representable range.
    function automatic logic sat_hit(input logic signed [AW-1:0] a,
                                     input logic signed [AW-1:0] b);
        logic [AW:0] sum;
        sum = {a[AW-1], a} + {b[AW-1], b};
        sat_hit = sum[AW] ^ sum[AW-1];
    endfunction

    // Tap operand select: one-hot OR mux keyed by the running tap index.
    always_comb begin
        tap_d_s = '0;
        tap_c_s = '0;
        for (int k = 0; k < ORDER; k++) begin
            tap_d_s = tap_d_s | ((idx_r == ADRW'(k)) ? dly_r[k]  : {DW{1'b0}});
            tap_c_s = tap_c_s | ((idx_r == ADRW'(k)) ? coef_r[k] : {CW{1'b0}});
        end
    end

    // Full-precision product, sign-extended, then saturating accumulation.
    always_comb begin
        prod_s     = (DW+CW)'(tap_d_s) * (DW+CW)'(tap_c_s);
        prod_ext_s = AW'(prod_s);
        acc_nxt_s  = sat_add(acc_r, prod_ext_s);
        acc_hit_s  = sat_hit(acc_r, prod_ext_s);
        addr_ok_s  = (coe_addr >= ADRW'(1)) && (coe_addr <= ADRW'(ORDER));
    end

    // Sequencer, delay line, coefficient store and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            acc_r        <= '0;
            dout_r       <= '0;
            din_ready_r  <= 1'b1;
            dout_valid_r <= 1'b0;
            coe_err_r    <= 1'b0;
            ovf_r        <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                dly_r[k]  <= '0;
                coef_r[k] <= '0;
            end
        end else begin
            dout_valid_r <= 1'b0;
            coe_err_r    <= 1'b0;

            // A write landing on the accept edge is visible to that sample's MAC pass.
            if (coe_we) begin
                if ((state_r == IDLE) && addr_ok_s) begin
                    for (int k = 0; k < ORDER; k++) begin
                        if (coe_addr == ADRW'(k + 1)) begin
                            coef_r[k] <= coe_data;
                        end
                    end
                end else begin
                    coe_err_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (din_valid) begin
                        dly_r[0] <= din;
                        for (int k = 1; k < ORDER; k++) begin
                            dly_r[k] <= dly_r[k-1];
                        end
                        acc_r       <= '0;
                        idx_r       <= '0;
                        state_r     <= MAC;
                        din_ready_r <= 1'b0;
                    end
                end
                MAC: begin
                    acc_r <= acc_nxt_s;
                    if (acc_hit_s) begin
                        ovf_r <= 1'b1;
                    end
                    idx_r <= idx_r + ADRW'(1);
                    if (idx_r == ADRW'(ORDER - 1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    dout_r       <= acc_r;
                    dout_valid_r <= 1'b1;
                    state_r      <= IDLE;
                    din_ready_r  <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    din_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign din_ready  = din_ready_r;
    assign dout_valid = dout_valid_r;
    assign dout       = dout_r;
    assign coe_err    = coe_err_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_iir_pole_mac.sv
// Directed + randomized bench for iir_pole_mac; two instances (AW=26 and AW=24)
// share inputs and are checked against a plain-arithmetic tap-sum model.
module tb_iir_pole_mac;
    localparam int DW    = 12;
    localparam int CW    = 12;
    localparam int ORDER = 7;
    localparam int ADRW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            din_valid = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            coe_we = 1'b0;
    logic [ADRW-1:0] coe_addr = '0;
    logic [CW-1:0]   coe_data = '0;

    logic        din_ready, coe_err, dout_valid, ovf;
    logic [25:0] dout;
    logic        din_ready_b, coe_err_b, dout_valid_b, ovf_b;
    logic [23:0] dout_b;

    int checks = 0;
    int errors = 0;

    longint hist[$];
    longint coef[ORDER];       // coef[k-1] is c[k]
    bit     movf_a, movf_b;
    longint exp_a, exp_b;
    longint qa[$], qb[$];

    always #5 clk = ~clk;

    iir_pole_mac dut_a (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data), .coe_err(coe_err),
        .dout_valid(dout_valid), .dout(dout), .ovf(ovf)
    );

    iir_pole_mac #(.AW(24)) dut_b (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready_b),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data), .coe_err(coe_err_b),
        .dout_valid(dout_valid_b), .dout(dout_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sum of c[k]*x[n-k+1], clamped after every addition to the aw-bit range.
    function automatic longint model_y(input int aw, output bit hit);
        longint acc, hi, lo;
        hi  = (longint'(1) <<< (aw - 1)) - 1;
        lo  = -(longint'(1) <<< (aw - 1));
        acc = 0;
        hit = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            acc += coef[k] * hist[k];
            if (acc > hi) begin acc = hi; hit = 1'b1; end
            else if (acc < lo) begin acc = lo; hit = 1'b1; end
        end
        return acc;
    endfunction

    task automatic model_accept(input int x);
        bit h;
        hist.push_front(longint'(x));
        void'(hist.pop_back());
        exp_a = model_y(26, h); if (h) movf_a = 1'b1;
        exp_b = model_y(24, h); if (h) movf_b = 1'b1;
    endtask

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < ORDER; k++) begin
            hist.push_back(0);
            coef[k] = 0;
        end
        movf_a = 1'b0;
        movf_b = 1'b0;
    endtask

    task automatic coef_write(input int addr, input int val, input bit exp_err);
        coe_we   = 1'b1;
        coe_addr = addr[ADRW-1:0];
        coe_data = val[CW-1:0];
        @(negedge clk);
        coe_we = 1'b0;
        check("coe_err_a", coe_err, exp_err);
        check("coe_err_b", coe_err_b, exp_err);
        if (!exp_err) coef[addr-1] = val;
    endtask

    // Offer one sample, measure accept-to-valid latency and compare both outputs.
    task automatic run_sample(input int x, input bit mac_wr);
        int n;
        din       = x[DW-1:0];
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 40) begin @(negedge clk); n++; end
        check("accept_ready", din_ready, 1'b1);
        model_accept(x);
        @(negedge clk);
        din_valid = 1'b0;
        coe_we    = 1'b0;
        check("busy_ready", din_ready, 1'b0);
        check("accept_err", coe_err, 1'b0);
        n = 0;
        while (!dout_valid && n < 40) begin
            if (mac_wr && n == 2) begin
                coe_we = 1'b1; coe_addr = 4'd2; coe_data = 12'sd77;
            end
            @(negedge clk);
            n++;
            if (mac_wr && n == 3) begin
                coe_we = 1'b0;
                check("mac_wr_err_a", coe_err, 1'b1);
                check("mac_wr_err_b", coe_err_b, 1'b1);
            end
        end
        check("dout_valid", dout_valid, 1'b1);
        check("latency", n, 8);
        check("dout_a", $signed(dout), exp_a);
        check("dout_b", $signed(dout_b), exp_b);
        check("ovf_a", ovf, movf_a);
        check("ovf_b", ovf_b, movf_b);
    endtask

    initial begin
        int imp_exp[ORDER];
        int last_acc, gaps, n;
        bit acc_now;
        imp_exp = '{-922, 1163, -811, 412, -122, 24, -2};
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", din_ready, 1'b1);
        check("rst_dout", $signed(dout), 0);
        check("rst_dv", dout_valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", coe_err, 1'b0);

        // Coefficient load and impulse response
        for (int k = 0; k < ORDER; k++) coef_write(k + 1, imp_exp[k], 1'b0);
        for (int i = 0; i < ORDER; i++) begin
            run_sample((i == 0) ? 1 : 0, 1'b0);
            check("impulse", $signed(dout), imp_exp[i]);
        end

        // Step response
        for (int i = 1; i <= 8; i++) begin
            run_sample(2047, 1'b0);
            if (i >= 7) begin
                check("step_val", $signed(dout), -528126);
                check("step_ovf", ovf, 1'b0);
            end
        end

        // Rejected writes: out-of-range addresses and a write during MAC
        coef_write(0, 999, 1'b1);
        coef_write(8, 999, 1'b1);
        run_sample(1, 1'b1);
        for (int i = 1; i < ORDER; i++) run_sample(0, 1'b0);
        check("reject_tail", $signed(dout), -2);

        // Coefficient write on the same edge as an accept
        coe_we = 1'b1; coe_addr = 4'd1; coe_data = -12'sd500;
        coef[0] = -500;
        run_sample(3, 1'b0);
        check("same_edge", $signed(dout), -1500);

        // Saturation on the AW=24 instance
        for (int k = 1; k <= ORDER; k++) coef_write(k, -2048, 1'b0);
        for (int i = 0; i < 8; i++) run_sample(-2048, 1'b0);
        check("sat_val_b", $signed(dout_b), 8388607);
        check("sat_ovf_b", ovf_b, 1'b1);
        check("sat_ovf_a", ovf, 1'b0);
        for (int k = 1; k <= ORDER; k++) coef_write(k, 3, 1'b0);
        for (int i = 0; i < 8; i++) run_sample($urandom_range(200) - 100, 1'b0);
        check("sticky_ovf_b", ovf_b, 1'b1);

        // Back-to-back random traffic with din_valid held high
        for (int k = 1; k <= ORDER; k++) coef_write(k, $urandom_range(4095) - 2048, 1'b0);
        din = 12'($urandom_range(4095));
        din_valid = 1'b1;
        last_acc = -1;
        gaps = 0;
        for (int t = 0; t < 110; t++) begin
            acc_now = 1'b0;
            if (dout_valid) begin
                check("b2b_pending", qa.size(), (qa.size() > 0) ? qa.size() : 1);
                if (qa.size() > 0) begin
                    check("b2b_a", $signed(dout), qa.pop_front());
                    check("b2b_b", $signed(dout_b), qb.pop_front());
                end
            end
            if (din_ready) begin
                if (last_acc >= 0) begin
                    check("b2b_gap", t - last_acc, 9);
                    gaps++;
                end
                last_acc = t;
                model_accept($signed(din));
                qa.push_back(exp_a);
                qb.push_back(exp_b);
                acc_now = 1'b1;
            end
            @(negedge clk);
            if (acc_now) din = 12'($urandom_range(4095));
        end
        din_valid = 1'b0;
        n = 0;
        while (qa.size() > 0 && n < 40) begin
            if (dout_valid) begin
                check("drain_a", $signed(dout), qa.pop_front());
                check("drain_b", $signed(dout_b), qb.pop_front());
            end
            @(negedge clk);
            n++;
        end
        check("b2b_left", qa.size(), 0);
        check("b2b_gaps", gaps >= 10, 1'b1);
        check("b2b_ovf_b", ovf_b, movf_b);

        // Reset asserted mid-MAC
        din = 12'd5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_dout", $signed(dout), 0);
        check("mid_rst_dout_b", $signed(dout_b), 0);
        check("mid_rst_ovf_b", ovf_b, 1'b0);
        check("mid_rst_err", coe_err, 1'b0);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_dv", dout_valid, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_dv", dout_valid, 1'b0);
        end
        check("post_rst_ready", din_ready, 1'b1);
        run_sample(1, 1'b0);
        check("post_rst_imp", $signed(dout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_pole_mac.md
Name: iir_pole_mac

Overview:
- Parametrised, time-multiplexed successor to the fully parallel pole (feedback) section of the direct-form IIR filters.
- Computes y = sum over k=1..ORDER of c[k]*x[n-k+1] with a single shared multiplier-accumulator, one tap per clock.
- Coefficients are run-time loadable; input and output use a valid/ready handshake.
- Sits between the zero section and the output/feedback adder of the IIR datapath, clocked much faster than the sample rate.

Parameters:
- DW, 12, input sample width (signed)
- CW, 12, coefficient width (signed)
- ORDER, 7, number of pole taps (2..15)
- ADRW, 4, coefficient address width; must satisfy 2^ADRW >= ORDER+1
- AW, 26, accumulator/output width; must be >= DW+CW

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- din_valid  in  1  input sample valid
- din  in  DW  signed input sample
- din_ready  out  1  block can accept a sample
- coe_we  in  1  coefficient write strobe
- coe_addr  in  ADRW  coefficient index k, valid range 1..ORDER
- coe_data  in  CW  signed coefficient value
- coe_err  out  1  one-cycle pulse: rejected coefficient write
- dout_valid  out  1  one-cycle pulse: dout updated
- dout  out  AW  signed filtered result, held between updates
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - delay line d[0..ORDER-1] and coefficients c[1..ORDER] to 0
  - accumulator, dout, dout_valid, coe_err and ovf to 0
  - state to IDLE, so din_ready=1 once rst is released
- Reset asserted mid-computation aborts it; no dout_valid is issued.
- States:
  - IDLE: din_ready=1. On din_valid at a clock edge, the sample is accepted:
    - d[0] <= din and d[j] <= d[j-1]
    - accumulator <= 0, tap index <= 0, state <= MAC
  - MAC: lasts exactly ORDER cycles. Each cycle, acc <= sat(acc + ext(c[idx+1]*d[idx])) and idx increments. After the cycle with idx=ORDER-1, state <= DONE.
  - DONE: dout <= final accumulator and dout_valid=1 for this single cycle, then state <= IDLE.
- din_ready=0 in MAC and DONE. din_valid is ignored there and the sample is not captured; the source must hold it.
- Latency: dout_valid is asserted ORDER+1 cycles after the accepting edge.
- Throughput: one sample per ORDER+2 cycles when din_valid is held high.
- Arithmetic:
  - Product is full-precision signed, DW+CW bits, sign-extended to AW.
  - Accumulation saturates to [-2^(AW-1), 2^(AW-1)-1].
  - Any saturation sets ovf, which clears only on reset.
  - No rounding or truncation is applied.
- Coefficient writes:
  - Accepted only in IDLE with 1<=coe_addr<=ORDER; c[coe_addr] is updated at that edge.
  - A write in MAC/DONE or with an out-of-range address is dropped, and coe_err pulses for one cycle.
  - If coe_we and an accepted din_valid occur at the same IDLE edge, both take effect. The coefficient written at that edge is used in the computation that sample starts.
- dout holds its value until the next DONE. Zero coefficients still consume their MAC cycle, so latency stays fixed.

Test Plan:
- Reset and load:
  - Stimulus: release reset; load c1..c7 = -922, 1163, -811, 412, -122, 24, -2; send an impulse din = 1, 0, 0, 0, 0, 0, 0.
  - Required: dout = -922, 1163, -811, 412, -122, 24, -2 on successive pulses, each exactly 8 cycles after its accept.
- Step response:
  - Stimulus: same coefficients, din held at 2047 for 8 samples.
  - Required: from the 7th output onward, dout = -528126 and ovf stays 0.
- Saturation:
  - Stimulus: override AW=24; set all coefficients to -2048; din held at -2048.
  - Required: dout = 8388607 (positive saturation) and ovf=1, remaining 1 after further normal samples until reset.
- Back-to-back handshake:
  - Stimulus: din_valid held high with changing din.
  - Required: accepts occur every 9 cycles; din_ready=0 for 8 cycles after each accept; no sample is lost or duplicated against the reference model.
- Coefficient rejection:
  - Stimulus: coe_we during MAC, and coe_we with coe_addr=0 or 8 in IDLE.
  - Required: coe_err pulses once for each; the coefficients are unchanged, so the next impulse output matches the previous coefficient set.
- Reset mid-MAC:
  - Stimulus: drive rst low 3 cycles after an accept.
  - Required: all outputs are 0 immediately; no dout_valid; after release, din_ready=1 and the delay line and coefficients read back as 0, so an impulse gives dout = 0.
